// File: rtl/bit_scatter_1to8.sv
// Serial (bit, lane) beats -> LANES-wide word with lane mask and beat count, valid/ready both sides.
// Optional BIT_SCATTER_PARITY_EN adds a registered m_parity output of the written lanes.
module bit_scatter_1to8 #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned AUTO_FLUSH = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    input  logic [SEL_W-1:0] s_sel,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LANES-1:0] m_data,
    output logic [LANES-1:0] m_mask,
    output logic [SEL_W:0]   m_count,
`ifdef BIT_SCATTER_PARITY_EN
    output logic             m_parity,
`endif
    output logic             err_dup,
    output logic             err_rng
);

    localparam int unsigned CW = SEL_W + 1;
    localparam logic [CW-1:0] CMAX    = '1;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    typedef enum logic {
        O_IDLE = 1'b0,
        O_FULL = 1'b1
    } ostate_t;

    ostate_t ostate, ostate_nxt;

    logic [LANES-1:0] acc_data, acc_mask;
    logic [CW-1:0]    acc_count;

    logic             accept;
    logic             in_rng;
    logic             dup;
    logic             complete;
    logic [LANES-1:0] sel_oh;
    logic [LANES-1:0] data_nxt, mask_nxt;
    logic [CW-1:0]    count_nxt;

    assign m_valid = (ostate == O_FULL);
    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // Post-update view of the accumulator for the beat being offered
    always_comb begin
        in_rng    = ({1'b0, s_sel} < LANES_C);
        sel_oh    = in_rng ? (LANES'(1) << s_sel) : '0;
        dup       = |(acc_mask & sel_oh);
        mask_nxt  = acc_mask | sel_oh;
        data_nxt  = (acc_data & ~sel_oh) | (s_bit ? sel_oh : '0);
        count_nxt = (acc_count == CMAX) ? CMAX : acc_count + CW'(1);
        complete  = accept && (s_last || ((AUTO_FLUSH != 0) && (&mask_nxt)));
    end

    // Accumulator and error pulses
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_data  <= '0;
            acc_mask  <= '0;
            acc_count <= '0;
            err_dup   <= 1'b0;
            err_rng   <= 1'b0;
        end else begin
            err_dup <= accept && dup;
            err_rng <= accept && !in_rng;
            if (complete) begin
                acc_data  <= '0;
                acc_mask  <= '0;
                acc_count <= '0;
            end else if (accept) begin
                acc_data  <= data_nxt;
                acc_mask  <= mask_nxt;
                acc_count <= count_nxt;
            end
        end
    end

    // Output FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ostate <= O_IDLE;
        end else begin
            ostate <= ostate_nxt;
        end
    end

    // A completing beat always (re)loads; otherwise drain on m_ready
    always_comb begin
        ostate_nxt = ostate;
        case (ostate)
            O_IDLE: if (complete) ostate_nxt = O_FULL;
            O_FULL: begin
                if (complete)     ostate_nxt = O_FULL;
                else if (m_ready) ostate_nxt = O_IDLE;
            end
            default: ostate_nxt = O_IDLE;
        endcase
    end

    // Output word register, written only by completing beats
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_data  <= '0;
            m_mask  <= '0;
            m_count <= '0;
        end else if (complete) begin
            m_data  <= data_nxt;
            m_mask  <= mask_nxt;
            m_count <= count_nxt;
        end
    end

`ifdef BIT_SCATTER_PARITY_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_parity <= 1'b0;
        end else if (complete) begin
            m_parity <= ^(data_nxt & mask_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_bit_scatter_1to8.sv
// Directed bench for bit_scatter_1to8: 8-lane auto-flush instance and 6-lane last-only instance.
module tb_bit_scatter_1to8;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic       s_valid, s_ready, s_bit, s_last, m_valid, m_ready, err_dup, err_rng;
    logic [2:0] s_sel;
    logic [7:0] m_data, m_mask;
    logic [3:0] m_count;

    logic       b_s_valid, b_s_ready, b_s_bit, b_s_last, b_m_valid, b_m_ready, b_err_dup, b_err_rng;
    logic [2:0] b_s_sel;
    logic [5:0] b_m_data, b_m_mask;
    logic [3:0] b_m_count;
`ifdef BIT_SCATTER_PARITY_EN
    logic m_parity, b_m_parity;
`endif

    int checks = 0;
    int errors = 0;

    bit_scatter_1to8 #(.LANES(8), .SEL_W(3), .AUTO_FLUSH(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit), .s_sel(s_sel), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_mask(m_mask), .m_count(m_count),
`ifdef BIT_SCATTER_PARITY_EN
        .m_parity(m_parity),
`endif
        .err_dup(err_dup), .err_rng(err_rng)
    );

    bit_scatter_1to8 #(.LANES(6), .SEL_W(3), .AUTO_FLUSH(0)) dut6 (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_bit(b_s_bit), .s_sel(b_s_sel), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_mask(b_m_mask), .m_count(b_m_count),
`ifdef BIT_SCATTER_PARITY_EN
        .m_parity(b_m_parity),
`endif
        .err_dup(b_err_dup), .err_rng(b_err_rng)
    );

    task automatic send(input logic [2:0] sel, input logic b, input logic last);
        int n = 0;
        s_valid = 1'b1; s_sel = sel; s_bit = b; s_last = last;
        while (!s_ready && n < 50) begin @(posedge aclk); #1; n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL send_timeout s_ready=%b required 1", s_ready); end
        @(posedge aclk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send6(input logic [2:0] sel, input logic b, input logic last);
        int n = 0;
        b_s_valid = 1'b1; b_s_sel = sel; b_s_bit = b; b_s_last = last;
        while (!b_s_ready && n < 50) begin @(posedge aclk); #1; n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL send6_timeout s_ready=%b required 1", b_s_ready); end
        @(posedge aclk); #1;
        b_s_valid = 1'b0; b_s_last = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %b exp 1", s_ready); end
        checks++; if ({m_data, m_mask, m_count} !== 20'h0) begin errors++; $display("FAIL rst_word got %h/%h/%h exp 0", m_data, m_mask, m_count); end
        checks++; if ({err_dup, err_rng} !== 2'b00) begin errors++; $display("FAIL rst_err got %b exp 00", {err_dup, err_rng}); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        send(3'd0, 1'b1, 1'b0);
        send(3'd1, 1'b1, 1'b0);
        send(3'd2, 1'b1, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid v/r got %b%b exp 01", m_valid, s_ready); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        send(3'd5, 1'b0, 1'b1);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h00 || m_mask !== 8'h20 || m_count !== 4'd1) begin
            errors++; $display("FAIL rst_next_word got v%b d%h m%h c%0d exp v1 d00 m20 c1", m_valid, m_data, m_mask, m_count);
        end
    endtask

    task automatic test_full_word();
        for (int i = 0; i < 8; i++) begin
            send(3'(i), i[0], 1'b0);
            if (i == 6) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b exp 0", m_valid); end
            end
        end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hAA || m_mask !== 8'hFF || m_count !== 4'd8) begin
            errors++; $display("FAIL full_word got v%b d%h m%h c%0d exp v1 dAA mFF c8", m_valid, m_data, m_mask, m_count);
        end
`ifdef BIT_SCATTER_PARITY_EN
        checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL full_parity got %b exp 0", m_parity); end
`endif
        @(posedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_one_cycle got %b exp 0", m_valid); end
    endtask

    task automatic test_early_last();
        send(3'd2, 1'b1, 1'b0);
        send(3'd5, 1'b1, 1'b1);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h24 || m_mask !== 8'h24 || m_count !== 4'd2) begin
            errors++; $display("FAIL early_last got v%b d%h m%h c%0d exp v1 d24 m24 c2", m_valid, m_data, m_mask, m_count);
        end
    endtask

    task automatic test_duplicate();
        send(3'd3, 1'b1, 1'b0);
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_first got %b exp 0", err_dup); end
        send(3'd3, 1'b0, 1'b1);
        checks++; if (err_dup !== 1'b1) begin errors++; $display("FAIL dup_pulse got %b exp 1", err_dup); end
        checks++; if (m_data !== 8'h00 || m_mask !== 8'h08 || m_count !== 4'd2) begin
            errors++; $display("FAIL dup_word got d%h m%h c%0d exp d00 m08 c2", m_data, m_mask, m_count);
        end
        @(posedge aclk); #1;
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_clear got %b exp 0", err_dup); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send(3'd1, 1'b1, 1'b1);
        s_valid = 1'b1; s_sel = 3'd4; s_bit = 1'b1; s_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            checks++; if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h02 || m_mask !== 8'h02 || m_count !== 4'd1) begin
                errors++; $display("FAIL stall_%0d got r%b v%b d%h m%h c%0d exp r0 v1 d02 m02 c1", i, s_ready, m_valid, m_data, m_mask, m_count);
            end
        end
        m_ready = 1'b1;
        @(posedge aclk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h10 || m_mask !== 8'h10 || m_count !== 4'd1) begin
            errors++; $display("FAIL drain_load got v%b d%h m%h c%0d exp v1 d10 m10 c1", m_valid, m_data, m_mask, m_count);
        end
        @(posedge aclk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got %b exp 0", m_valid); end
    endtask

    task automatic test_parity();
        logic [7:0] w;
        w = 8'hA1;
        for (int i = 0; i < 8; i++) send(3'(i), w[i], 1'b0);
        checks++; if (m_data !== 8'hA1 || m_mask !== 8'hFF) begin errors++; $display("FAIL par_word got d%h m%h exp dA1 mFF", m_data, m_mask); end
`ifdef BIT_SCATTER_PARITY_EN
        checks++; if (m_parity !== 1'b1) begin errors++; $display("FAIL par_bit got %b exp 1", m_parity); end
`endif
    endtask

    task automatic test_range();
        send6(3'd7, 1'b1, 1'b1);
        checks++; if (b_err_rng !== 1'b1) begin errors++; $display("FAIL rng_pulse got %b exp 1", b_err_rng); end
        checks++; if (b_m_valid !== 1'b1 || b_m_data !== 6'h00 || b_m_mask !== 6'h00 || b_m_count !== 4'd1) begin
            errors++; $display("FAIL rng_word got v%b d%h m%h c%0d exp v1 d00 m00 c1", b_m_valid, b_m_data, b_m_mask, b_m_count);
        end
        @(posedge aclk); #1;
        checks++; if (b_err_rng !== 1'b0) begin errors++; $display("FAIL rng_clear got %b exp 0", b_err_rng); end
    endtask

    task automatic test_no_autoflush();
        for (int i = 0; i < 6; i++) send6(3'(i), 1'b1, 1'b0);
        checks++; if (b_m_valid !== 1'b0) begin errors++; $display("FAIL noflush_valid got %b exp 0", b_m_valid); end
        send6(3'd2, 1'b0, 1'b1);
        checks++; if (b_m_valid !== 1'b1 || b_m_data !== 6'h3B || b_m_mask !== 6'h3F || b_m_count !== 4'd7 || b_err_dup !== 1'b1) begin
            errors++; $display("FAIL noflush_word got v%b d%h m%h c%0d dup%b exp v1 d3b m3f c7 dup1", b_m_valid, b_m_data, b_m_mask, b_m_count, b_err_dup);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) send6(3'd0, 1'b1, 1'b0);
        send6(3'd1, 1'b0, 1'b1);
        checks++; if (b_m_count !== 4'd15 || b_m_data !== 6'h01 || b_m_mask !== 6'h03) begin
            errors++; $display("FAIL sat_word got d%h m%h c%0d exp d01 m03 c15", b_m_data, b_m_mask, b_m_count);
        end
    endtask

    initial begin
        s_valid = 1'b0; s_bit = 1'b0; s_sel = 3'd0; s_last = 1'b0; m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_bit = 1'b0; b_s_sel = 3'd0; b_s_last = 1'b0; b_m_ready = 1'b1;
        test_reset();
        test_full_word();
        test_early_last();
        test_duplicate();
        test_backpressure();
        test_parity();
        test_range();
        test_no_autoflush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
